// File: rtl/btn_pkg.sv
// Shared types and helpers for the multi-button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESSING,
    PRESSED,
    RELEASING
  } btn_state_e;

  // Bits needed for a counter that must be able to hold the largest of three limits.
  function automatic int unsigned cnt_width_req(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchroniser, symmetric press/release debounce
// FSM and registered level/press/release outputs.
// Optional auto-repeat of the press strobe while held: define BTN_AUTOREPEAT_EN.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int unsigned MINWIDTH      = 5000000,
  parameter int unsigned COUNTERWIDTH  = 32,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic rel
);

  if (MINWIDTH < 2) begin : g_bad_minwidth
    $error("btn_debounce_chan: MINWIDTH must be >= 2");
  end

  if (COUNTERWIDTH < cnt_width_req(MINWIDTH, HOLD_CYCLES, REPEAT_CYCLES)) begin : g_bad_width
    $error("btn_debounce_chan: COUNTERWIDTH too narrow for MINWIDTH/HOLD_CYCLES/REPEAT_CYCLES");
  end

  localparam logic [COUNTERWIDTH-1:0] CNT_ONE  = COUNTERWIDTH'(1);
  localparam logic [COUNTERWIDTH-1:0] CNT_LAST = COUNTERWIDTH'(MINWIDTH - 1);

  logic sync1_q, sync2_q;

  btn_state_e state_q, state_d;
  logic [COUNTERWIDTH-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic rel_q, rel_d;
  logic fsm_press;

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM: a run of MINWIDTH disagreeing samples commits a new level.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fsm_press = 1'b0;
    rel_d     = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESSING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESSING: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          fsm_press = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      RELEASING: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASING);
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [COUNTERWIDTH-1:0] HOLD_LAST = COUNTERWIDTH'(HOLD_CYCLES - 1);
  localparam logic [COUNTERWIDTH-1:0] REP_LAST  = COUNTERWIDTH'(REPEAT_CYCLES - 1);

  logic [COUNTERWIDTH-1:0] rpt_q, rpt_d;
  logic rpt_phase_q, rpt_phase_d;
  logic rpt_fire;

  // Repeat timer: counts only while steadily PRESSED; phase selects hold vs repeat period.
  // Any edge not spent in PRESSED with s=1 (commit, bounce, release) clears it.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_fire    = 1'b0;
    if ((state_q == PRESSED) && sync2_q) begin
      if (rpt_q == (rpt_phase_q ? REP_LAST : HOLD_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_d = rpt_q + CNT_ONE;
      end
    end else begin
      rpt_d       = '0;
      rpt_phase_d = 1'b0;
    end
  end

  // Repeat timer registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end

  assign press_d = fsm_press | rpt_fire;
`else
  assign press_d = fsm_press;
`endif

  // State, counter and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/multi_button_debouncer.sv
// Multi-channel push-button debouncer: NUM_BTNS independent channels.
// Optional auto-repeat of btn_press while held: define BTN_AUTOREPEAT_EN.
module multi_button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTNS      = 4,
  parameter int unsigned MINWIDTH      = 5000000,
  parameter int unsigned COUNTERWIDTH  = 32,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    btn_debounce_chan #(
      .MINWIDTH      (MINWIDTH),
      .COUNTERWIDTH  (COUNTERWIDTH),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_chan (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .btn_raw (btn_in[i]),
      .level   (btn_level[i]),
      .press   (btn_press[i]),
      .rel     (btn_release[i])
    );
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Scoreboard bench for multi_button_debouncer: directed scenarios then random
// button activity, checked against a run-length reference model.
module tb_multi_button_debouncer;

  localparam int unsigned NB = 2;
  localparam int unsigned MW = 4;
  localparam int unsigned HC = 10;
  localparam int unsigned RC = 3;

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic [NB-1:0] btn_in  = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  typedef struct packed {
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  bit          started     = 0;

  // reference model state
  logic [NB-1:0] m_p1, m_p2, m_lvl;
  int unsigned   m_run[NB];
  int unsigned   m_hold[NB];

  multi_button_debouncer #(
    .NUM_BTNS      (NB),
    .MINWIDTH      (MW),
    .COUNTERWIDTH  (8),
    .HOLD_CYCLES   (HC),
    .REPEAT_CYCLES (RC)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: a level flips after MW consecutive disagreeing samples;
  // samples reach the decision two edges after btn_in is captured.
  always @(posedge sys_clk) begin : ref_model
    obs_t          e;
    logic [NB-1:0] s;
    e = '0;
    if (!rst_n) begin
      m_p1  = '0;
      m_p2  = '0;
      m_lvl = '0;
      for (int i = 0; i < NB; i++) begin
        m_run[i]  = 0;
        m_hold[i] = 0;
      end
    end else begin
      s    = m_p2;
      m_p2 = m_p1;
      m_p1 = btn_in;
      for (int i = 0; i < NB; i++) begin
        if (s[i] != m_lvl[i]) begin
          m_hold[i] = 0;
          m_run[i]  = m_run[i] + 1;
          if (m_run[i] == MW) begin
            m_lvl[i] = s[i];
            m_run[i] = 0;
            if (s[i]) e.prs[i] = 1'b1;
            else      e.rel[i] = 1'b1;
          end
        end else begin
          if (m_lvl[i] && (m_run[i] == 0)) begin
            m_hold[i] = m_hold[i] + 1;
`ifdef BTN_AUTOREPEAT_EN
            if ((m_hold[i] == HC) || ((m_hold[i] > HC) && (((m_hold[i] - HC) % RC) == 0)))
              e.prs[i] = 1'b1;
`endif
          end
          m_run[i] = 0;
        end
      end
    end
    e.lvl = m_lvl;
    exp_q.push_back(e);
    started = 1;
  end

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  always @(negedge sys_clk) begin : monitor
    obs_t e, got;
    if (started) begin
      got = obs_t'({btn_level, btn_press, btn_release});
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty t=%0t got lvl=%b prs=%b rel=%b", $time,
                 got.lvl, got.prs, got.rel);
      end else begin
        e = exp_q.pop_front();
        if (!rst_n) e = '0;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b",
                   $time, got.lvl, got.prs, got.rel, e.lvl, e.prs, e.rel);
        end
      end
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset_now(input string name);
    vectors++;
    if ({btn_level, btn_press, btn_release} !== '0) begin
      miscompares++;
      $display("FAIL %s t=%0t got %b required 0", name, $time,
               {btn_level, btn_press, btn_release});
    end
  endtask

  initial begin : stimulus
    int unsigned   left[NB];
    logic [NB-1:0] v;

    // reset with both buttons held, then release reset
    rst_n  = 1'b0;
    btn_in = 2'b11;
    cyc(3);
    rst_n = 1'b1;
    cyc(12);
    btn_in = 2'b00;
    cyc(10);

    // clean press/release on ch0
    btn_in = 2'b01;
    cyc(20);
    btn_in = 2'b00;
    cyc(10);

    // press glitch on ch1, then a real press
    btn_in = 2'b10;
    cyc(3);
    btn_in = 2'b00;
    cyc(6);
    btn_in = 2'b10;
    cyc(6);
    btn_in = 2'b00;
    cyc(8);

    // release bounce on ch0 while pressed
    btn_in = 2'b01;
    cyc(8);
    btn_in = 2'b00;
    cyc(2);
    btn_in = 2'b01;
    cyc(8);
    btn_in = 2'b00;
    cyc(10);

    // simultaneous press; ch1 dropped while ch0 still counting
    btn_in = 2'b11;
    cyc(2);
    btn_in = 2'b01;
    cyc(12);
    btn_in = 2'b00;
    cyc(10);

    // reset mid-PRESSING, then long hold on ch0
    btn_in = 2'b01;
    cyc(4);
    rst_n = 1'b0;
    #1;
    check_reset_now("reset_async_clear");
    cyc(2);
    rst_n = 1'b1;
    cyc(30);
    btn_in = 2'b00;
    cyc(10);

    // random activity: mixed glitches and holds, rare resets
    v = '0;
    for (int i = 0; i < NB; i++) left[i] = 0;
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (left[i] == 0) begin
          v[i]    = ~v[i];
          left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 25);
        end
        left[i] = left[i] - 1;
      end
      btn_in = v;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        check_reset_now("reset_async_random");
        cyc(2);
        rst_n = 1'b1;
      end
      cyc(1);
    end

    btn_in = '0;
    cyc(12);
    @(negedge sys_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
